// File: rtl/onewire_pkg.sv
// Shared types and helpers for the 1-Wire slave: FSM states, low-time counter
// width and the microsecond-to-cycle conversion used for every bus timer.
`timescale 1ns/1ps
package onewire_pkg;

  localparam int LOW_CNT_W = 14;

  typedef enum logic [2:0] {
    IDLE,
    RST_LOW,
    PRES_WAIT,
    PRES_DRV,
    SLOT_LOW,
    SLOT_END
  } state_t;

  function automatic int us2cyc(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/onewire_line_sync.sv
// Bus input conditioning: 2-flop synchronizer, optional 3-sample majority filter
// (ONEWIRE_SLV_GLITCH_FILTER_EN), synced level and single-cycle fell/rose pulses.
`timescale 1ns/1ps
module onewire_line_sync (
  input  logic clk,
  input  logic arst_n,
  input  logic line,
  output logic level,
  output logic fell,
  output logic rose
);

  logic sync1;
  logic sync2;
  logic prev;

`ifdef ONEWIRE_SLV_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // Majority of three consecutive samples swallows any single-cycle pulse
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 2'b11;
      filt  <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      hist  <= {hist[0], sync2};
      filt  <= (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
      prev  <= filt;
    end
  end

  assign level = filt;
`else
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign level = sync2;
`endif

  assign fell = prev & ~level;
  assign rose = ~prev & level;

endmodule

// File: rtl/onewire_slave.sv
// Synthesizable 1-Wire slave: reset/presence handling, LSB-first byte receive
// and transmit in time slots. Optional input filter: ONEWIRE_SLV_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module onewire_slave
  import onewire_pkg::*;
#(
  parameter int CLK_HZ       = 10_000_000,
  parameter int T_RST_MIN_US = 400,
  parameter int T_PDH_US     = 30,
  parameter int T_PDL_US     = 120,
  parameter int T_SAMPLE_US  = 30,
  parameter int T_HOLD0_US   = 40
) (
  input  logic       clk,
  input  logic       arst_n,
  inout  wire        onewire,
  input  logic       tx_mode,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       tx_done,
  output logic       presence,
  output logic       busy
);

  localparam int TMR_W = 16;
  localparam logic [LOW_CNT_W-1:0] RST_LAST    = LOW_CNT_W'(us2cyc(CLK_HZ, T_RST_MIN_US) - 1);
  localparam logic [TMR_W-1:0]     PDH_LAST    = TMR_W'(us2cyc(CLK_HZ, T_PDH_US) - 1);
  localparam logic [TMR_W-1:0]     PDL_LAST    = TMR_W'(us2cyc(CLK_HZ, T_PDL_US) - 1);
  localparam logic [TMR_W-1:0]     SAMPLE_LAST = TMR_W'(us2cyc(CLK_HZ, T_SAMPLE_US) - 1);
  localparam logic [TMR_W-1:0]     HOLD0_LAST  = TMR_W'(us2cyc(CLK_HZ, T_HOLD0_US) - 1);

  state_t               state;
  logic [TMR_W-1:0]     timer;
  logic [LOW_CNT_W-1:0] low_cnt;
  logic [2:0]           bit_cnt;
  logic                 mode;
  logic [7:0]           tx_shift;
  logic [7:0]           shift;
  logic                 drive_low;
  logic                 level;
  logic                 fell;
  logic                 rose;
  logic                 rst_hit;
  logic                 slot_tx;
  logic                 slot_bit;

  assign onewire = drive_low ? 1'b0 : 1'bz;

  onewire_line_sync u_sync (
    .clk   (clk),
    .arst_n(arst_n),
    .line  (onewire),
    .level (level),
    .fell  (fell),
    .rose  (rose)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      low_cnt <= '0;
    end else if (level) begin
      low_cnt <= '0;
    end else if (low_cnt != '1) begin
      low_cnt <= low_cnt + 1'b1;
    end
  end

  // Gated by the live level so the rising edge out of a reset pulse is not overridden
  assign rst_hit = ~level & (low_cnt >= RST_LAST);

  // At a byte start the mode and first bit come straight from the inputs being latched
  assign slot_tx  = (bit_cnt == 3'd0) ? tx_mode : mode;
  assign slot_bit = (bit_cnt == 3'd0) ? tx_data[0] : tx_shift[bit_cnt];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      mode      <= 1'b0;
      tx_shift  <= '0;
      shift     <= '0;
      drive_low <= 1'b0;
      rx_data   <= 8'h00;
      rx_vld    <= 1'b0;
      tx_done   <= 1'b0;
      presence  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_vld   <= 1'b0;
      tx_done  <= 1'b0;
      presence <= 1'b0;
      timer    <= timer + 1'b1;
      if (rst_hit) begin
        state     <= RST_LOW;
        drive_low <= 1'b0;
        bit_cnt   <= '0;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (fell) begin
              state     <= SLOT_LOW;
              timer     <= '0;
              busy      <= 1'b1;
              drive_low <= slot_tx & ~slot_bit;
              if (bit_cnt == 3'd0) begin
                mode     <= tx_mode;
                tx_shift <= tx_data;
              end
            end
          end
          RST_LOW: begin
            if (rose) begin
              state <= PRES_WAIT;
              timer <= '0;
            end
          end
          PRES_WAIT: begin
            if (timer == PDH_LAST) begin
              state     <= PRES_DRV;
              timer     <= '0;
              drive_low <= 1'b1;
            end
          end
          PRES_DRV: begin
            if (timer == PDL_LAST) begin
              state     <= IDLE;
              drive_low <= 1'b0;
              presence  <= 1'b1;
              busy      <= 1'b0;
            end
          end
          SLOT_LOW: begin
            if (mode) begin
              if (timer == HOLD0_LAST) begin
                state     <= SLOT_END;
                drive_low <= 1'b0;
              end
            end else if (timer == SAMPLE_LAST) begin
              state          <= SLOT_END;
              shift[bit_cnt] <= level;
            end
          end
          SLOT_END: begin
            if (level) begin
              state   <= IDLE;
              busy    <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                if (mode) begin
                  tx_done <= 1'b1;
                end else begin
                  rx_data <= shift;
                  rx_vld  <= 1'b1;
                end
              end
            end
          end
          default: begin
            state     <= IDLE;
            drive_low <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onewire_slave.sv
// Bus-level bench for onewire_slave: a behavioural 1-Wire master drives reset,
// write and read slots; expectations come from constant tables and a byte model.
`timescale 1ns/1ps
module tb_onewire_slave;

  typedef struct {
    bit         mode;
    logic [7:0] data;
    int         exp_rx;
    int         exp_tx;
    logic [7:0] exp_val;
  } vec_t;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       master_low = 1'b0;
  logic       tx_mode = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       tx_done;
  logic       presence;
  logic       busy;
  wire        bus;

  int         checks = 0;
  int         errors = 0;
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         pres_cnt = 0;
  int         busy_cnt = 0;
  logic [7:0] rx_last = 8'h00;

  assign bus = master_low ? 1'b0 : 1'bz;
  pullup (bus);

  always #50 clk = ~clk;

  onewire_slave dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .onewire (bus),
    .tx_mode (tx_mode),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .tx_done (tx_done),
    .presence(presence),
    .busy    (busy)
  );

  always @(negedge clk) begin
    if (rx_vld) begin
      rx_cnt++;
      rx_last = rx_data;
    end
    if (tx_done) tx_cnt++;
    if (presence) pres_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkWindow(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic masterSlot(input int low_cyc, input int total_cyc);
    @(negedge clk);
    master_low = 1'b1;
    repeat (low_cyc) @(negedge clk);
    master_low = 1'b0;
    repeat (total_cyc - low_cyc) @(negedge clk);
  endtask

  task automatic writeBit(input bit b);
    if (b) masterSlot(60, 350);
    else   masterSlot(600, 650);
  endtask

  task automatic readBit(output bit b);
    @(negedge clk);
    master_low = 1'b1;
    repeat (60) @(negedge clk);
    master_low = 1'b0;
    repeat (70) @(negedge clk);
    b = bus;
    repeat (320) @(negedge clk);
  endtask

  task automatic writeByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) writeBit(v[i]);
  endtask

  task automatic readByte(output logic [7:0] v);
    bit b;
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      v[i] = b;
    end
  endtask

  // Offsets are counted in cycles from the master's release of the reset pulse
  task automatic resetPulse(output int first, output int len);
    @(negedge clk);
    master_low = 1'b1;
    repeat (4800) @(negedge clk);
    master_low = 1'b0;
    first = -1;
    len   = 0;
    for (int i = 1; i <= 1550; i++) begin
      @(negedge clk);
      if (bus == 1'b0) begin
        if (first < 0) first = i;
        len++;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int d_rx, output int d_tx, output int val);
    int         rx0;
    int         tx0;
    logic [7:0] rb;
    rx0 = rx_cnt;
    tx0 = tx_cnt;
    @(negedge clk);
    tx_mode = v.mode;
    tx_data = v.data;
    if (v.mode) begin
      readByte(rb);
      val = int'(rb);
    end else begin
      writeByte(v.data);
      repeat (5) @(negedge clk);
      val = int'(rx_last);
    end
    repeat (20) @(negedge clk);
    d_rx = rx_cnt - rx0;
    d_tx = tx_cnt - tx0;
  endtask

  initial begin
    vec_t       vecs[4];
    int         first, len, d_rx, d_tx, val;
    int         rx0, tx0, pres0, busy0;
    int         exp_busy, exp_rx;
    logic [7:0] last0;
    bit         b;
    int         nbits;
    bit         m_mode;
    logic [7:0] m_tx;
    int         m_acc, m_n;

    vecs[0] = '{mode: 1'b0, data: 8'h41, exp_rx: 1, exp_tx: 0, exp_val: 8'h41};
    vecs[1] = '{mode: 1'b1, data: 8'hA5, exp_rx: 0, exp_tx: 1, exp_val: 8'hA5};
    vecs[2] = '{mode: 1'b0, data: 8'h00, exp_rx: 1, exp_tx: 0, exp_val: 8'h00};
    vecs[3] = '{mode: 1'b1, data: 8'h3C, exp_rx: 0, exp_tx: 1, exp_val: 8'h3C};

    repeat (5) @(negedge clk);
    checkOutput("reset_rx_data", int'(rx_data), 0);
    checkOutput("reset_rx_vld", int'(rx_vld), 0);
    checkOutput("reset_tx_done", int'(tx_done), 0);
    checkOutput("reset_presence", int'(presence), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_bus_released", int'(bus), 1);
    arst_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] reset pulse and presence");
    pres0 = pres_cnt;
    rx0   = rx_cnt;
    resetPulse(first, len);
    checkWindow("presence_start", first, 298, 308);
    checkWindow("presence_len", len, 1198, 1202);
    checkOutput("presence_pulses", pres_cnt - pres0, 1);
    checkOutput("presence_no_rx", rx_cnt - rx0, 0);
    checkOutput("presence_busy_clear", int'(busy), 0);

    $display("[TB] table vectors");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i], d_rx, d_tx, val);
      checkOutput($sformatf("vec%0d_rx_vld_count", i), d_rx, vecs[i].exp_rx);
      checkOutput($sformatf("vec%0d_tx_done_count", i), d_tx, vecs[i].exp_tx);
      checkOutput($sformatf("vec%0d_value", i), val, int'(vecs[i].exp_val));
    end

    $display("[TB] partial byte then reset");
    @(negedge clk);
    tx_mode = 1'b0;
    rx0 = rx_cnt;
    pres0 = pres_cnt;
    writeBit(1'b1);
    writeBit(1'b0);
    writeBit(1'b1);
    resetPulse(first, len);
    checkOutput("partial_no_rx", rx_cnt - rx0, 0);
    checkOutput("partial_presence", pres_cnt - pres0, 1);
    writeByte(8'h3C);
    repeat (20) @(negedge clk);
    checkOutput("after_reset_rx_count", rx_cnt - rx0, 1);
    checkOutput("after_reset_rx_data", int'(rx_last), 8'h3C);

    $display("[TB] long write-0 slot and mid-byte mode change");
    rx0 = rx_cnt;
    tx0 = tx_cnt;
    pres0 = pres_cnt;
    masterSlot(3000, 3100);
    checkOutput("long_low_no_presence", pres_cnt - pres0, 0);
    @(negedge clk);
    tx_mode = 1'b1;
    tx_data = 8'hFF;
    for (int i = 1; i < 8; i++) writeBit(((8'h5A >> i) & 8'h01) != 8'h00);
    repeat (20) @(negedge clk);
    checkOutput("long_low_rx_count", rx_cnt - rx0, 1);
    checkOutput("long_low_tx_count", tx_cnt - tx0, 0);
    checkOutput("long_low_rx_data", int'(rx_last), 8'h5A);
    tx_mode = 1'b0;

    $display("[TB] single-cycle glitch");
`ifdef ONEWIRE_SLV_GLITCH_FILTER_EN
    exp_busy = 0;
    exp_rx   = 0;
`else
    exp_busy = 1;
    exp_rx   = 1;
`endif
    rx0 = rx_cnt;
    busy0 = busy_cnt;
    last0 = rx_last;
    @(negedge clk);
    master_low = 1'b1;
    @(negedge clk);
    master_low = 1'b0;
    repeat (400) @(negedge clk);
    checkOutput("glitch_busy", int'(busy_cnt > busy0), exp_busy);
    for (int i = 0; i < 7; i++) writeBit(1'b0);
    repeat (20) @(negedge clk);
    checkOutput("glitch_rx_count", rx_cnt - rx0, exp_rx);
    checkOutput("glitch_rx_data", int'(rx_last), (exp_rx != 0) ? 8'h01 : int'(last0));
    pres0 = pres_cnt;
    resetPulse(first, len);
    checkOutput("glitch_cleanup_presence", pres_cnt - pres0, 1);

    $display("[TB] randomized bytes against byte model");
    for (int it = 0; it < 4; it++) begin
      nbits = (it == 2) ? int'($urandom_range(1, 3)) : 8;
      @(negedge clk);
      tx_mode = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
      rx0 = rx_cnt;
      tx0 = tx_cnt;
      m_n = 0;
      m_acc = 0;
      m_mode = 1'b0;
      m_tx = 8'h00;
      for (int k = 0; k < nbits; k++) begin
        if (m_n == 0) begin
          m_mode = tx_mode;
          m_tx   = tx_data;
        end
        if (!m_mode) begin
          b = 1'($urandom_range(0, 1));
          writeBit(b);
          m_acc = m_acc | (int'(b) << m_n);
        end else begin
          readBit(b);
          checkOutput($sformatf("rand%0d_read_bit%0d", it, m_n), int'(b), int'((m_tx >> m_n) & 8'h01));
        end
        m_n++;
        if (k == 1) begin
          tx_mode = 1'($urandom_range(0, 1));
          tx_data = 8'($urandom);
        end
      end
      repeat (20) @(negedge clk);
      if (nbits == 8) begin
        checkOutput($sformatf("rand%0d_rx_count", it), rx_cnt - rx0, m_mode ? 0 : 1);
        checkOutput($sformatf("rand%0d_tx_count", it), tx_cnt - tx0, m_mode ? 1 : 0);
        if (!m_mode) checkOutput($sformatf("rand%0d_rx_data", it), int'(rx_last), m_acc);
      end else begin
        pres0 = pres_cnt;
        resetPulse(first, len);
        checkOutput($sformatf("rand%0d_abort_rx", it), rx_cnt - rx0, 0);
        checkOutput($sformatf("rand%0d_abort_tx", it), tx_cnt - tx0, 0);
        checkOutput($sformatf("rand%0d_abort_presence", it), pres_cnt - pres0, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
